uart_rx_buffer: RTL and testbench
=================================

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, meaning sysclk frequency in Hz.
REQ-002 Parameter BAUD, default 9600, meaning serial bit rate.
REQ-003 Parameter DEPTH, default 4, meaning receive FIFO entries; SHALL be a power of two, at least 2.
REQ-004 Port sysclk, input, 1, sole clock; all logic rising-edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port UART_RX, input, 1, asynchronous serial line; idle high.
REQ-007 Port rd_en, input, 1, pop pulse, one byte per asserted cycle.
REQ-008 Port clr_err, input, 1, clears sticky error flags.
REQ-009 Port rd_data, output, 8, FIFO head (show-ahead); valid only while empty=0.
REQ-010 Port empty, output, 1, FIFO holds no bytes.
REQ-011 Port count, output, $clog2(DEPTH)+1, bytes currently held.
REQ-012 Port frame_err, output, 1, sticky: stop bit sampled low.
REQ-013 Port overrun, output, 1, sticky: byte completed while FIFO full.
REQ-014 Port rx_irq, output, 1, equals ~empty; feeds the processor interrupt OR.

Function
REQ-015 UART_RX SHALL pass through a 2-flop synchroniser before any use.
REQ-016 The oversample tick SHALL pulse once every DIV = CLK_FREQ/(BAUD*16) sysclk cycles, integer-truncated; the divider SHALL restart on start-bit detection.
REQ-017 The FSM SHALL use states IDLE, START, DATA, STOP, plus PARITY under REQ-031.
REQ-018 IDLE->START on a synchronised 1->0 transition of the line.
REQ-019 START: at tick 8, line low -> DATA; line high -> IDLE (glitch rejected, nothing recorded).
REQ-020 DATA: sample every 16 ticks from the start-bit midpoint; 8 bits, LSB first; after bit 7 -> STOP.
REQ-021 STOP: sample at midpoint; high -> push byte; low -> set frame_err and discard byte; either case -> IDLE.
REQ-022 The pushed byte SHALL be in the FIFO and empty SHALL deassert on the sysclk edge after the stop-bit sample edge.
REQ-023 A push while full and without rd_en SHALL discard the new byte, set overrun, and leave stored data unchanged.
REQ-024 rd_en while empty SHALL be ignored: no pointer or count change.
REQ-025 Simultaneous push and pop SHALL both succeed, including when full, with count unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-027 clr_err SHALL clear both flags next cycle; a same-cycle error set SHALL win over clear.

Reset
REQ-028 Reset low SHALL asynchronously force: FSM=IDLE; pointers, count, divider and bit counter=0; synchroniser flops=1; empty=1; frame_err=0; overrun=0; rd_data=0.
REQ-029 Reset mid-frame SHALL abandon the frame; reception resumes on the next falling edge after release.
REQ-030 FIFO storage SHALL need no reset; rd_data SHALL read 0 whenever empty=1.

Configuration
REQ-031 With UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA; an even-parity bit is sampled, and a mismatch sets frame_err and discards the byte. Without it, frames are 8N1 and no parity logic exists.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE=16, and the START midpoint constant 8.
REQ-033 Sub-module baud_tick_gen SHALL implement the restartable divider of REQ-016; FIFO and FSM stay in uart_rx_buffer.

Verification (CLK_FREQ=1600000, BAUD=10000: DIV=10, bit=160 cycles)
REQ-034 Send 0xA5 as 8N1 -> empty falls about 1520 cycles after the start edge; rd_data=0xA5, count=1, rx_irq=1; frame_err and overrun remain 0.
REQ-035 Send 5 bytes 0x01..0x05 with no reads (DEPTH=4) -> count=4, overrun=1; popping returns 0x01..0x04, then empty=1.
REQ-036 Send 0x3C with the stop bit held low -> frame_err=1, empty stays 1; pulse clr_err -> frame_err=0.
REQ-037 Hold line low for 40 cycles then release -> FSM returns to IDLE; no byte and no flag; a following 0x55 is received correctly.
REQ-038 With FIFO full, assert rd_en in the same cycle as a push of 0x77 -> count stays 4, overrun=0, 0x77 is the last byte read out.
REQ-039 Assert reset low during bit 3 of a frame -> all outputs take their reset values immediately; the next full 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state encoding and oversampling constants shared by the UART receive path.
// UART_RX_PARITY_EN adds the PARITY state and the even-parity helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } rx_state_e;

`ifdef UART_RX_PARITY_EN
  // Value of the parity bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: oversample tick divider, one tick every DIV clocks.
// restart realigns the count so ticks are phased from the start-bit edge.
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Divider counter, cleared on restart and on wrap
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a show-ahead FIFO, with sticky frame/overrun flags.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     UART_RX,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     rx_irq
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int AW      = $clog2(DEPTH);
  localparam logic [3:0]  OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  MID_LAST = 4'(START_MID - 1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [1:0]  sync_r;
  logic        rx_prev_r;
  logic        rx_s, fall_s, tick_s, restart_s;
  rx_state_e   state_r, state_s;
  logic [3:0]  os_cnt_r, os_cnt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  shift_r, shift_s;
  logic        push_r, push_s, fe_set_s;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [AW:0]   count_r, count_s;
  logic          empty_r, full_s, pop_s, wr_s, ovr_set_s;
  logic [7:0]    rd_data_r, head_s;
  logic          frame_err_r, overrun_r;

  assign rx_s   = sync_r[1];
  assign fall_s = rx_prev_r & ~rx_s;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Receiver next-state: all samples taken on the last tick of each 16-tick bit window
  always_comb begin
    state_s   = state_r;
    os_cnt_s  = os_cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    push_s    = 1'b0;
    fe_set_s  = 1'b0;
    restart_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_s   = START;
          os_cnt_s  = 4'd0;
          bit_cnt_s = 3'd0;
          restart_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (!tick_s) begin
          state_s = START;
        end else if (os_cnt_r == MID_LAST) begin
          os_cnt_s = 4'd0;
          state_s  = rx_s ? IDLE : DATA;
        end else begin
          os_cnt_s = os_cnt_r + 4'd1;
        end
      end
      DATA: begin
        if (!tick_s) begin
          state_s = DATA;
        end else if (os_cnt_r == OS_LAST) begin
          os_cnt_s  = 4'd0;
          shift_s   = {rx_s, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          os_cnt_s = os_cnt_r + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick_s) begin
          state_s = PARITY;
        end else if (os_cnt_r == OS_LAST) begin
          os_cnt_s = 4'd0;
          if (rx_s != even_parity(shift_r)) begin
            fe_set_s = 1'b1;
            state_s  = IDLE;
          end else begin
            state_s = STOP;
          end
        end else begin
          os_cnt_s = os_cnt_r + 4'd1;
        end
      end
`endif
      STOP: begin
        if (!tick_s) begin
          state_s = STOP;
        end else if (os_cnt_r == OS_LAST) begin
          os_cnt_s = 4'd0;
          state_s  = IDLE;
          if (rx_s) begin
            push_s = 1'b1;
          end else begin
            fe_set_s = 1'b1;
          end
        end else begin
          os_cnt_s = os_cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Synchroniser, edge detector and receiver state registers
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync_r    <= 2'b11;
      rx_prev_r <= 1'b1;
      state_r   <= IDLE;
      os_cnt_r  <= 4'd0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      push_r    <= 1'b0;
    end else begin
      sync_r    <= {sync_r[0], UART_RX};
      rx_prev_r <= sync_r[1];
      state_r   <= state_s;
      os_cnt_r  <= os_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      push_r    <= push_s;
    end
  end

  // FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
  always_comb begin
    full_s    = (count_r == CNT_FULL);
    pop_s     = rd_en & ~empty_r;
    wr_s      = push_r & (~full_s | pop_s);
    ovr_set_s = push_r & full_s & ~pop_s;
    rd_ptr_s  = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    wr_ptr_s  = wr_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    case ({wr_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
    if (count_s == '0) begin
      head_s = 8'd0;
    end else if (wr_s && (rd_ptr_s == wr_ptr_r)) begin
      head_s = shift_r;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // FIFO storage, deliberately without reset
  always_ff @(posedge sysclk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= shift_r;
    end
  end

  // FIFO pointers, occupancy and registered show-ahead head
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      empty_r   <= 1'b1;
      rd_data_r <= 8'd0;
    end else begin
      wr_ptr_r  <= wr_ptr_s;
      rd_ptr_r  <= rd_ptr_s;
      count_r   <= count_s;
      empty_r   <= (count_s == '0);
      rd_data_r <= head_s;
    end
  end

  // Sticky error flags; a new error in the clearing cycle is kept
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= fe_set_s | (frame_err_r & ~clr_err);
      overrun_r   <= ovr_set_s | (overrun_r & ~clr_err);
    end
  end

  assign rd_data   = rd_data_r;
  assign empty     = empty_r;
  assign count     = count_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign rx_irq    = ~empty_r;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: serial frames driven bit-by-bit, checked against a queue-based model
// of the receive FIFO and sticky flags.
module tb_uart_rx_buffer;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int DEPTH    = 4;
  localparam int BIT      = 160;

  logic       sysclk = 1'b0;
  logic       reset, UART_RX, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, frame_err, overrun, rx_irq;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = -1;

  logic [7:0] model_q[$];
  logic       m_fe, m_ovr;

  always #5 sysclk = ~sysclk;

  uart_rx_buffer #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .empty(empty), .count(count), .frame_err(frame_err),
    .overrun(overrun), .rx_irq(rx_irq)
  );

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk); #1;
    end
  endtask

  // Drives one frame; k counts edges since the start bit was driven.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int pop_at,
                            input int abort_at, input bit measure);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int k = 0; k < 10 * BIT; k++) begin
      if (k == abort_at) break;
      UART_RX = bits[k / BIT];
      rd_en   = (k + 1 == pop_at);
      @(posedge sysclk); #1;
      if (measure && lat < 0 && !empty) lat = k + 1;
    end
    rd_en = 1'b0;
    if (abort_at < 0) begin
      UART_RX = 1'b1;
      idle(40);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_bit);
    if (!stop_bit) m_fe = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge sysclk); #1;
    rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge sysclk); #1;
    clr_err = 1'b0;
    m_fe = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; UART_RX = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    m_fe = 1'b0; m_ovr = 1'b0;
    idle(5);
    n_checks++;
    if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 8'd0 || frame_err !== 1'b0 ||
        overrun !== 1'b0 || rx_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: empty=%b count=%0d rd_data=%h fe=%b ovr=%b irq=%b required 1 0 00 0 0 0",
               empty, count, rd_data, frame_err, overrun, rx_irq);
    end
    reset = 1'b1;
    idle(20);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1, -1, 1'b1);
    model_frame(8'hA5, 1'b1);
    n_checks++;
    if (lat < 1500 || lat > 1540) begin
      n_fail++; $display("FAIL single_latency: %0d cycles required about 1520", lat);
    end
    n_checks++;
    if (rd_data !== 8'hA5 || count !== 3'd1 || rx_irq !== 1'b1) begin
      n_fail++; $display("FAIL single_data: rd_data=%h count=%0d irq=%b required a5 1 1", rd_data, count, rx_irq);
    end
    n_checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL single_flags: fe=%b ovr=%b required 0 0", frame_err, overrun);
    end
    pop_one();
    n_checks++;
    if (empty !== 1'b1 || rd_data !== 8'd0 || rx_irq !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: empty=%b rd_data=%h irq=%b required 1 00 0", empty, rd_data, rx_irq);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, -1, 1'b0);
      model_frame(8'(i), 1'b1);
    end
    n_checks++;
    if (count !== 3'(model_q.size()) || overrun !== m_ovr) begin
      n_fail++; $display("FAIL overrun_state: count=%0d ovr=%b required %0d %b", count, overrun, model_q.size(), m_ovr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rd_data !== model_q[0]) begin
        n_fail++; $display("FAIL overrun_pop%0d: rd_data=%h required %h", i, rd_data, model_q[0]);
      end
      pop_one();
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      n_fail++; $display("FAIL overrun_drain: empty=%b count=%0d required 1 0", empty, count);
    end
    pulse_clr();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: ovr=%b required 0", overrun);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, -1, -1, 1'b0);
    model_frame(8'h3C, 1'b0);
    n_checks++;
    if (frame_err !== m_fe || empty !== 1'b1 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL frame_err_set: fe=%b empty=%b ovr=%b required %b 1 0", frame_err, empty, overrun, m_fe);
    end
    pulse_clr();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL frame_err_clear: fe=%b required 0", frame_err);
    end
  endtask

  task automatic test_glitch();
    UART_RX = 1'b0;
    idle(40);
    UART_RX = 1'b1;
    idle(300);
    n_checks++;
    if (empty !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL glitch_reject: empty=%b fe=%b ovr=%b required 1 0 0", empty, frame_err, overrun);
    end
    send_frame(8'h55, 1'b1, -1, -1, 1'b0);
    model_frame(8'h55, 1'b1);
    n_checks++;
    if (rd_data !== 8'h55 || count !== 3'd1) begin
      n_fail++; $display("FAIL glitch_next: rd_data=%h count=%0d required 55 1", rd_data, count);
    end
    pop_one();
  endtask

  task automatic test_full_pop();
    logic [7:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, -1, -1, 1'b0);
      model_frame(d, 1'b1);
    end
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++; $display("FAIL full_fill: count=%0d required 4", count);
    end
    // The pop lands on the push edge; the model pops first so 0x77 fits.
    send_frame(8'h77, 1'b1, lat, -1, 1'b0);
    void'(model_q.pop_front());
    model_frame(8'h77, 1'b1);
    n_checks++;
    if (count !== 3'd4 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_push: count=%0d ovr=%b required 4 0", count, overrun);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (rd_data !== model_q[0]) begin
        n_fail++; $display("FAIL full_pop_order%0d: rd_data=%h required %h", i, rd_data, model_q[0]);
      end
      pop_one();
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h9A, 1'b1, -1, -1, 1'b0);
    model_frame(8'h9A, 1'b1);
    send_frame(8'hC3, 1'b1, -1, 4 * BIT + 80, 1'b0);
    reset = 1'b0;
    #1;
    model_q.delete();
    m_fe = 1'b0; m_ovr = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || count !== 3'd0 || rd_data !== 8'd0 || frame_err !== 1'b0 ||
        overrun !== 1'b0 || rx_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: empty=%b count=%0d rd_data=%h fe=%b ovr=%b irq=%b required 1 0 00 0 0 0",
               empty, count, rd_data, frame_err, overrun, rx_irq);
    end
    idle(3);
    UART_RX = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(200);
    send_frame(8'hC3, 1'b1, -1, -1, 1'b0);
    model_frame(8'hC3, 1'b1);
    n_checks++;
    if (rd_data !== 8'hC3 || count !== 3'd1 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_resume: rd_data=%h count=%0d fe=%b required c3 1 0", rd_data, count, frame_err);
    end
    pop_one();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       sb;
    int         npop;
    for (int it = 0; it < 8; it++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, sb, -1, -1, 1'b0);
      model_frame(d, sb);
      n_checks++;
      if (count !== 3'(model_q.size()) || empty !== (model_q.size() == 0) ||
          frame_err !== m_fe || overrun !== m_ovr) begin
        n_fail++;
        $display("FAIL random_state%0d: count=%0d empty=%b fe=%b ovr=%b required %0d %b %b %b",
                 it, count, empty, frame_err, overrun, model_q.size(), model_q.size() == 0, m_fe, m_ovr);
      end
      n_checks++;
      if (rd_data !== ((model_q.size() == 0) ? 8'd0 : model_q[0])) begin
        n_fail++; $display("FAIL random_head%0d: rd_data=%h required %h", it, rd_data,
                           (model_q.size() == 0) ? 8'd0 : model_q[0]);
      end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) pop_one();
      if (m_fe || m_ovr) pulse_clr();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_full_pop();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
